// File: rtl/inst_sram_fetch_ctrl_pkg.sv
// Shared types and constants for the uncached instruction fetch sequencer.
package inst_sram_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INST_ADDR_RST = 32'h0;

endpackage

// File: rtl/inst_sram_fetch_ctrl_if.sv
// SRAM-like instruction bus between the fetch sequencer (master) and memory (slave).
interface inst_sram_fetch_ctrl_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_bus_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_bus_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_bus_rdata
    );

endinterface

// File: rtl/inst_sram_fetch_ctrl.sv
// Uncached instruction fetch sequencer: one outstanding bus read, word held until consumed.
// Define INST_FETCH_BYPASS_EN to forward bus data to the stage in the data_ok cycle.
//
// state | meaning
// IDLE  | no transaction
// REQ   | inst_req high, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// HOLD  | word buffered, inst_valid high
module inst_sram_fetch_ctrl
    import inst_sram_fetch_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   pc,
    input  logic                          fetch_en,
    input  logic                          advance,
    input  logic                          flush,
    output logic                          inst_valid,
    output logic [31:0]                   inst_rdata,
    output logic                          busy,
    output logic [31:0]                   perf_fetch_cnt,
    inst_sram_fetch_ctrl_if.master        bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]  state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_en && !flush) begin
                    state_d = S_REQ;
                    addr_d  = pc;
                end
            end
            S_REQ: begin
                // The request must stay up until accepted; a flush only marks it for discard.
                if (flush) drop_d = 1'b1;
                if (bus.inst_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (drop_q || flush) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        buf_d = bus.inst_bus_rdata;
`ifdef INST_FETCH_BYPASS_EN
                        if (advance) begin
                            state_d = S_IDLE;
                            cnt_d   = cnt_q + 32'd1;
                        end else begin
                            state_d = S_HOLD;
                        end
`else
                        state_d = S_HOLD;
`endif
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (advance) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            addr_q  <= INST_ADDR_RST;
            buf_q   <= 32'h0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef INST_FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = (state_q == S_WAIT) && bus.inst_data_ok && !drop_q && !flush;
    assign inst_valid = (state_q == S_HOLD) || bypass_hit;
    assign inst_rdata = bypass_hit ? bus.inst_bus_rdata : buf_q;
`else
    assign inst_valid = (state_q == S_HOLD);
    assign inst_rdata = buf_q;
`endif

    assign busy           = (state_q == S_REQ) || (state_q == S_WAIT);
    assign bus.inst_req   = (state_q == S_REQ);
    assign bus.inst_addr  = addr_q;
    assign perf_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_sram_fetch_ctrl.sv
// Self-checking bench for inst_sram_fetch_ctrl: directed scenarios then random traffic vs a transaction model.
module tb_inst_sram_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_en;
    logic        advance;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        busy;
    logic [31:0] perf_fetch_cnt;

    inst_sram_fetch_ctrl_if bus_if ();

    inst_sram_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .fetch_en       (fetch_en),
        .advance        (advance),
        .flush          (flush),
        .inst_valid     (inst_valid),
        .inst_rdata     (inst_rdata),
        .busy           (busy),
        .perf_fetch_cnt (perf_fetch_cnt),
        .bus            (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: one outstanding read, its acceptance, whether it was
    // cancelled by a flush, and the word currently held for the stage.
    bit          m_out;
    bit          m_acc;
    bit          m_cancel;
    bit          m_have;
    logic [31:0] m_addr;
    logic [31:0] m_word;
    logic [31:0] m_cnt;

    task check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task set_in(input bit fe, input bit adv, input bit fl, input bit aok, input bit dok,
                input logic [31:0] rd);
        fetch_en              = fe;
        advance               = adv;
        flush                 = fl;
        bus_if.inst_addr_ok   = aok;
        bus_if.inst_data_ok   = dok;
        bus_if.inst_bus_rdata = rd;
    endtask

    task model_step();
        if (reset) begin
            m_out = 0; m_acc = 0; m_cancel = 0; m_have = 0;
            m_addr = 32'h0; m_word = 32'h0; m_cnt = 32'h0;
        end else if (m_have) begin
            if (flush) m_have = 0;
            else if (advance) begin
                m_have = 0;
                m_cnt  = m_cnt + 32'd1;
            end
        end else if (m_out) begin
            if (!m_acc) begin
                if (flush) m_cancel = 1;
                if (bus_if.inst_addr_ok) m_acc = 1;
            end else if (bus_if.inst_data_ok) begin
                m_out = 0;
                if (m_cancel || flush) m_cancel = 0;
                else begin
                    m_word = bus_if.inst_bus_rdata;
`ifdef INST_FETCH_BYPASS_EN
                    if (advance) m_cnt = m_cnt + 32'd1;
                    else m_have = 1;
`else
                    m_have = 1;
`endif
                end
            end else if (flush) begin
                m_cancel = 1;
            end
        end else if (fetch_en && !flush) begin
            m_out = 1; m_acc = 0; m_cancel = 0;
            m_addr = pc;
        end
    endtask

    // Inputs are already applied (at the falling edge); compare, advance the model, next falling edge.
    task cycle();
        bit hit;
        #1;
        hit = 0;
`ifdef INST_FETCH_BYPASS_EN
        hit = m_out && m_acc && bus_if.inst_data_ok && !m_cancel && !flush;
`endif
        check_eq("valid", inst_valid, m_have || hit);
        check_eq("rdata", inst_rdata, hit ? bus_if.inst_bus_rdata : m_word);
        check_eq("req",   bus_if.inst_req, m_out && !m_acc);
        check_eq("addr",  bus_if.inst_addr, m_addr);
        check_eq("busy",  busy, m_out);
        check_eq("cnt",   perf_fetch_cnt, m_cnt);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Fetch of a: request, immediate addr_ok, data_ok after one idle cycle.
    task fetch_word(input logic [31:0] a, input logic [31:0] w);
        pc = a;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 1, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 1, w);     cycle();
    endtask

    initial begin
        reset = 1'b1;
        pc    = 32'h0;
        set_in(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_req",   bus_if.inst_req, 0);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_addr",  bus_if.inst_addr, 32'h0);
        check_eq("rst_rdata", inst_rdata, 32'h0);
        check_eq("rst_cnt",   perf_fetch_cnt, 32'h0);

        // Basic fetch
        pc = 32'hBFC00000;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        check_eq("basic_req",  bus_if.inst_req, 1);
        check_eq("basic_addr", bus_if.inst_addr, 32'hBFC00000);
        set_in(0, 0, 0, 1, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 1, 32'h24020001); cycle();
        check_eq("basic_valid", inst_valid, 1);
        check_eq("basic_rdata", inst_rdata, 32'h24020001);
        set_in(0, 1, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("basic_cnt", perf_fetch_cnt, 1);

        // Flush in WAIT, then a clean fetch
        pc = 32'hBFC00100;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 1, 0, 32'h0); cycle();
        set_in(0, 0, 1, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 1, 32'hDEADBEEF);
        check_eq("fw_valid_dok", inst_valid, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("fw_valid_after", inst_valid, 0);
        check_eq("fw_busy_after",  busy, 0);
        fetch_word(32'hBFC00380, 32'h3C1DA000);
        set_in(0, 1, 0, 0, 0, 32'h0);
        check_eq("fw_new_valid", inst_valid, 1);
        check_eq("fw_new_rdata", inst_rdata, 32'h3C1DA000);
        cycle();

        // Flush coinciding with addr_ok
        pc = 32'hBFC00400;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 1, 1, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 1, 32'h11111111); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("fa_valid", inst_valid, 0);
        check_eq("fa_busy",  busy, 0);
        fetch_word(32'hBFC00480, 32'h22222222);
        set_in(0, 1, 0, 0, 0, 32'h0);
        check_eq("fa_next_rdata", inst_rdata, 32'h22222222);
        cycle();

        // Flush coinciding with data_ok
        pc = 32'hBFC00500;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 1, 0, 32'h0); cycle();
        set_in(0, 0, 1, 0, 1, 32'h33333333);
        check_eq("fd_valid_dok", inst_valid, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("fd_valid", inst_valid, 0);
        check_eq("fd_busy",  busy, 0);
        check_eq("fd_rdata", inst_rdata, 32'h22222222);
        cycle();

        // Stall in HOLD, then flush in HOLD
        fetch_word(32'hBFC00600, 32'h44444444);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 0, 32'h0);
            check_eq("stall_valid", inst_valid, 1);
            check_eq("stall_rdata", inst_rdata, 32'h44444444);
            check_eq("stall_req",   bus_if.inst_req, 0);
            cycle();
        end
        set_in(0, 1, 1, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("hflush_valid", inst_valid, 0);
        check_eq("hflush_cnt",   perf_fetch_cnt, 3);
        cycle();

        // Reset during WAIT, then a stray data_ok
        pc = 32'hBFC00700;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 1, 0, 32'h0); cycle();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 32'h0); cycle();
        reset = 1'b0;
        set_in(0, 1, 0, 0, 1, 32'h55555555); cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("rw_valid", inst_valid, 0);
        check_eq("rw_busy",  busy, 0);
        check_eq("rw_req",   bus_if.inst_req, 0);
        check_eq("rw_addr",  bus_if.inst_addr, 32'h0);
        check_eq("rw_rdata", inst_rdata, 32'h0);
        check_eq("rw_cnt",   perf_fetch_cnt, 32'h0);
        cycle();

`ifdef INST_FETCH_BYPASS_EN
        // Bypass: data_ok and advance together, next request two cycles later
        pc = 32'hBFC00800;
        set_in(1, 0, 0, 0, 0, 32'h0); cycle();
        set_in(0, 0, 0, 1, 0, 32'h0); cycle();
        set_in(0, 1, 0, 0, 1, 32'h66666666);
        check_eq("byp_valid", inst_valid, 1);
        check_eq("byp_rdata", inst_rdata, 32'h66666666);
        cycle();
        pc = 32'hBFC00880;
        set_in(1, 0, 0, 0, 0, 32'h0);
        check_eq("byp_idle_req", bus_if.inst_req, 0);
        check_eq("byp_cnt",      perf_fetch_cnt, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 32'h0);
        check_eq("byp_next_req", bus_if.inst_req, 1);
        cycle();
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            if (!m_out && !m_have) pc = $urandom;
            fetch_en = $urandom_range(0, 1);
            advance  = $urandom_range(0, 1);
            flush    = ($urandom_range(0, 9) == 0);
            bus_if.inst_addr_ok   = (m_out && !m_acc) ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (m_out && m_acc)
                bus_if.inst_data_ok = ($urandom_range(0, 2) == 0);
            else if (!m_out && !m_have)
                bus_if.inst_data_ok = ($urandom_range(0, 19) == 0);
            else
                bus_if.inst_data_ok = 1'b0;
            bus_if.inst_bus_rdata = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_sram_fetch_ctrl.md
# inst_sram_fetch_ctrl

Sequencer for the uncached instruction fetch path. It drives the SRAM-like instruction bus for the fetch stage and holds each returned word until the stage consumes it. It also drops responses whose request was cancelled by an exception flush. It sits between the fetch stage and the instruction bus, and produces the stage's uncached-path valid and data.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc  in  32  fetch address; stable while the stage is not advancing
- fetch_en  in  1  the stage wants an uncached fetch of pc
- advance  in  1  the stage consumes inst_rdata this cycle
- flush  in  1  exception flush; cancels the current fetch
- inst_valid  out  1  inst_rdata is valid for the last issued address
- inst_rdata  out  32  fetched instruction word
- busy  out  1  a bus transaction is outstanding (REQ or WAIT)
- inst_req  out  1  bus request
- inst_addr  out  32  bus address, latched copy of pc
- inst_addr_ok  in  1  bus accepted the request
- inst_data_ok  in  1  bus returns data this cycle
- inst_bus_rdata  in  32  bus read data, valid with inst_data_ok
- perf_fetch_cnt  out  32  count of words delivered to the stage

## Operation
- States:
  - IDLE: no transaction.
  - REQ: inst_req high, waiting for addr_ok.
  - WAIT: waiting for data_ok.
  - HOLD: word buffered, inst_valid high.
- drop: 1-bit flag. When set, the pending response must be discarded.
- IDLE:
  - fetch_en & !flush → REQ; latch inst_addr ← pc.
  - Otherwise stay in IDLE.
  - inst_data_ok is ignored in IDLE.
- REQ:
  - inst_req = 1. The request is never withdrawn before inst_addr_ok.
  - inst_addr_ok → WAIT.
  - flush sets drop. This also applies when flush coincides with addr_ok.
- WAIT:
  - inst_data_ok & !drop & !flush → HOLD; buffer inst_bus_rdata.
  - inst_data_ok & (drop | flush) → IDLE; clear drop; the word is discarded.
  - flush without data_ok sets drop.
- HOLD:
  - advance → IDLE.
  - flush → IDLE; the buffer is invalidated and perf_fetch_cnt is not incremented.
  - Otherwise hold.
- inst_valid = (state == HOLD). inst_rdata = buffer register.
- perf_fetch_cnt increments by 1 on each HOLD & advance & !flush. It wraps from 0xFFFFFFFF to 0.
- advance while inst_valid = 0 is ignored.
- busy = (state == REQ) | (state == WAIT).
- One outstanding transaction at most. A new request is issued only from IDLE.

## Timing
- Reset values:
  - State IDLE; drop = 0.
  - inst_req = 0, inst_valid = 0, busy = 0.
  - inst_addr = 0, inst_rdata = 0, perf_fetch_cnt = 0.
- Reset mid-transaction returns to IDLE. A data_ok that arrives later lands in IDLE and is ignored.
- Latency with the bus answering addr_ok in the cycle it sees the request:
  - fetch_en at cycle 0 → inst_req at cycle 1.
  - With data_ok at cycle n ≥ 2, inst_valid is high at cycle n+1.
- HOLD & advance at cycle m → IDLE at m+1. The next fetch_en is sampled at m+1.
- flush has priority over every other transition in the same cycle.

## Configuration
- INST_FETCH_BYPASS_EN defined:
  - In WAIT with inst_data_ok & !drop & !flush, inst_valid is asserted combinationally and inst_rdata = inst_bus_rdata.
  - If advance is also high in that cycle → IDLE directly and perf_fetch_cnt increments. Otherwise → HOLD, as in the undefined case.
  - This saves one cycle per fetch.
- Undefined: inst_valid is purely registered (HOLD only). There is no combinational path from the bus to the stage.

## Structure
- Shared package: enum fetch_state_e {IDLE, REQ, WAIT, HOLD} and the localparam for the reset value of inst_addr (32'h0).
- Single module; no sub-module. The buffer, drop flag and counter are local registers.

## Test plan
- Basic fetch: fetch_en with pc = 0xBFC00000, addr_ok immediate, data_ok at cycle 3 with 0x24020001, advance at 4 → inst_req at cycle 1 with inst_addr = 0xBFC00000; inst_valid at 4 with 0x24020001; perf_fetch_cnt = 1.
- Flush in WAIT: flush at cycle 2, data_ok at cycle 4 → inst_valid stays 0; state IDLE at 5; a new fetch at 0xBFC00380 returns its own data.
- Flush coinciding with addr_ok: the late data_ok is dropped and the next fetch succeeds. Flush coinciding with data_ok: the word is discarded and the block returns to IDLE.
- Stall in HOLD: advance held low for 5 cycles → inst_valid and inst_rdata stable, no new inst_req. Flush in HOLD → IDLE and the counter is unchanged.
- Reset during WAIT, followed by a stray data_ok → all outputs at reset values; the stray word is never presented.
- With INST_FETCH_BYPASS_EN: data_ok and advance in the same cycle → inst_valid is high in that cycle and the next inst_req is issued 2 cycles later.
